// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's cache, memory-arbiter and decode-side signals.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_fetch_if #(
  parameter int ADDR_W = 18
);
  logic              rdy;
  logic              jump_i;
  logic [31:0]       jump_addr_i;
  logic              stall_i;
  logic [31:0]       raddr_o;
  logic              hit_i;
  logic [31:0]       inst_i;
  logic              we_o;
  logic [31:0]       waddr_o;
  logic [31:0]       winst_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic [7:0]        mem_data_i;
  logic              if_valid_o;
  logic [31:0]       if_pc_o;
  logic [31:0]       if_inst_o;

  modport master (
    input  rdy, jump_i, jump_addr_i, stall_i, hit_i, inst_i, mem_gnt_i, mem_data_i,
    output raddr_o, we_o, waddr_o, winst_o, mem_req_o, mem_addr_o,
           if_valid_o, if_pc_o, if_inst_o
  );

  modport slave (
    output rdy, jump_i, jump_addr_i, stall_i, hit_i, inst_i, mem_gnt_i, mem_data_i,
    input  raddr_o, we_o, waddr_o, winst_o, mem_req_o, mem_addr_o,
           if_valid_o, if_pc_o, if_inst_o
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: looks up the icache every cycle at the PC, and on a
// miss assembles the 32-bit word from four byte reads (little-endian), writes
// it back to the cache for one cycle, then re-hits. Jumps abort any fill.
module if_fetch #(
  parameter int          ADDR_W   = 18,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic          clk,
  input logic          rst,
  if_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  issued_q, issued_d;
  logic [2:0]  recvd_q, recvd_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] buf_q, buf_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        fill_req_s;

  // A byte request is outstanding while filling and fewer than four were issued.
  assign fill_req_s      = (state_q == FILL) && (issued_q < 3'd4);

  assign bus.raddr_o    = pc_q;
  assign bus.mem_req_o  = bus.rdy && fill_req_s;
  assign bus.mem_addr_o = pc_q[ADDR_W-1:0] + {{(ADDR_W-3){1'b0}}, issued_q};
  assign bus.we_o       = bus.rdy && (state_q == WRITE);
  assign bus.waddr_o    = pc_q;
  assign bus.winst_o    = buf_q;
  assign bus.if_valid_o = if_valid_q;
  assign bus.if_pc_o    = if_pc_q;
  assign bus.if_inst_o  = if_inst_q;

  // Next-state logic: frozen when not ready, jump wins, otherwise the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    issued_d   = issued_q;
    recvd_d    = recvd_q;
    rvalid_d   = rvalid_q;
    buf_d      = buf_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    if (!bus.rdy) begin
      state_d = state_q;
    end else if (bus.jump_i) begin
      // Redirect drops any partial fill and any byte arriving this cycle.
      pc_d       = bus.jump_addr_i;
      if_valid_d = 1'b0;
      state_d    = IDLE;
      issued_d   = 3'd0;
      recvd_d    = 3'd0;
      rvalid_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.hit_i) begin
            if (!(bus.stall_i && if_valid_q)) begin
              if_valid_d = 1'b1;
              if_pc_d    = pc_q;
              if_inst_d  = bus.inst_i;
              pc_d       = pc_q + 32'd4;
            end else begin
              if_valid_d = if_valid_q;
            end
          end else begin
            state_d  = FILL;
            issued_d = 3'd0;
            recvd_d  = 3'd0;
            rvalid_d = 1'b0;
            if (!bus.stall_i) begin
              if_valid_d = 1'b0;
            end else begin
              if_valid_d = if_valid_q;
            end
          end
        end

        FILL: begin
          // Issue side: a grant makes the byte due on the following cycle.
          if (bus.mem_gnt_i && fill_req_s) begin
            issued_d = issued_q + 3'd1;
            rvalid_d = 1'b1;
          end else begin
            rvalid_d = 1'b0;
          end
          // Receive side overlaps with issue to sustain one byte per cycle.
          if (rvalid_q) begin
            buf_d[{recvd_q[1:0], 3'b000} +: 8] = bus.mem_data_i;
            recvd_d = recvd_q + 3'd1;
            if (recvd_q == 3'd3) begin
              state_d = WRITE;
            end else begin
              state_d = FILL;
            end
          end else begin
            recvd_d = recvd_q;
          end
          if (!bus.stall_i) begin
            if_valid_d = 1'b0;
          end else begin
            if_valid_d = if_valid_q;
          end
        end

        WRITE: begin
          // The cache forwards this write, so IDLE re-hits on the next cycle.
          state_d = IDLE;
          if (!bus.stall_i) begin
            if_valid_d = 1'b0;
          end else begin
            if_valid_d = if_valid_q;
          end
        end

        default: begin
          state_d  = IDLE;
          issued_d = 3'd0;
          recvd_d  = 3'd0;
          rvalid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      issued_q   <= 3'd0;
      recvd_q    <= 3'd0;
      rvalid_q   <= 1'b0;
      buf_q      <= 32'd0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      issued_q   <= issued_d;
      recvd_q    <= recvd_d;
      rvalid_q   <= rvalid_d;
      buf_q      <= buf_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a byte-addressed memory, a direct-mapped
// cache model and an arbiter model surround the DUT; deliveries and cache
// writes are compared against the instruction stream read from memory.
module tb_if_fetch;
  localparam int ADDR_W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_if #(.ADDR_W(ADDR_W)) bus ();
  if_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Memory and cache models
  logic [7:0]  mem     [0:1023];
  logic        c_valid [0:255];
  logic [21:0] c_tag   [0:255];
  logic [31:0] c_data  [0:255];
  logic        gnt_en;

  assign bus.hit_i     = c_valid[bus.raddr_o[9:2]] && (c_tag[bus.raddr_o[9:2]] == bus.raddr_o[31:10]);
  assign bus.inst_i    = c_data[bus.raddr_o[9:2]];
  assign bus.mem_gnt_i = bus.mem_req_o & gnt_en;

  int checks = 0;
  int errors = 0;

  // Per-cycle bookkeeping
  int cyc, n_grants, held, gnt_mode, gap_len, we_cnt, we_cyc, req_cnt;
  logic [ADDR_W-1:0] grant_addr[$];
  logic        s_rdy, s_gnt, s_req, s_we, s_valid, s_stall;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0] s_waddr, s_winst, s_pc, s_inst, s_raddr, we_addr, we_data;

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [9:0] b;
    b = a[9:0];
    return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    c_valid[a[9:2]] = 1'b1;
    c_tag[a[9:2]]   = a[31:10];
    c_data[a[9:2]]  = d;
  endtask

  // One clock cycle: choose grant, sample outputs mid-cycle, then apply the
  // cache write and the memory response after the edge.
  task automatic step();
    case (gnt_mode)
      0:       gnt_en = 1'b1;
      1:       gnt_en = !(n_grants == 1 && held < gap_len);
      2:       gnt_en = ($urandom_range(0, 3) != 0);
      default: gnt_en = 1'b1;
    endcase
    @(negedge clk);
    s_rdy = bus.rdy;       s_gnt = bus.mem_gnt_i;  s_req = bus.mem_req_o;
    s_addr = bus.mem_addr_o; s_we = bus.we_o;      s_waddr = bus.waddr_o;
    s_winst = bus.winst_o; s_valid = bus.if_valid_o; s_pc = bus.if_pc_o;
    s_inst = bus.if_inst_o; s_stall = bus.stall_i;  s_raddr = bus.raddr_o;
    if (gnt_mode == 1 && n_grants == 1 && s_req && !s_gnt) held++;
    if (s_gnt) begin n_grants++; grant_addr.push_back(s_addr); end
    if (s_req) req_cnt++;
    if (s_we) begin we_cnt++; we_cyc = cyc; we_addr = s_waddr; we_data = s_winst; end
    @(posedge clk);
    #1;
    if (s_we) preload(s_waddr, s_winst);
    if (s_rdy) bus.mem_data_i = s_gnt ? mem[s_addr[9:0]] : 8'($urandom);
    cyc++;
  endtask

  task automatic do_reset();
    bus.rdy = 1'b1; bus.jump_i = 1'b0; bus.jump_addr_i = 32'd0; bus.stall_i = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 256; i++) c_valid[i] = 1'b0;
    grant_addr.delete();
    n_grants = 0; held = 0; we_cnt = 0; we_cyc = -1; req_cnt = 0;
    we_addr = 32'd0; we_data = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Runs until if_valid_o is seen; returns the cycle it was seen, -1 on timeout.
  task automatic run_to_valid(output int vcyc);
    vcyc = -1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (s_valid) begin vcyc = cyc - 1; break; end
    end
  endtask

  task automatic test_reset();
    gnt_mode = 0;
    do_reset();
    checks++; if (bus.if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.if_valid_o); end
    checks++; if (bus.if_pc_o !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.if_pc_o); end
    checks++; if (bus.if_inst_o !== 32'd0) begin errors++; $display("FAIL reset_inst got %h exp 0", bus.if_inst_o); end
    checks++; if (bus.raddr_o !== 32'd0) begin errors++; $display("FAIL reset_raddr got %h exp 0", bus.raddr_o); end
    checks++; if (bus.we_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_we_req got %b%b exp 00", bus.we_o, bus.mem_req_o); end
    // Reset in the middle of a fill must clear the request immediately.
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus.mem_req_o !== 1'b1) begin errors++; $display("FAIL midfill_req got %b exp 1", bus.mem_req_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL async_rst_req got %b exp 0", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== '0) begin errors++; $display("FAIL async_rst_addr got %h exp 0", bus.mem_addr_o); end
  endtask

  task automatic test_cold_miss();
    int vcyc;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h13;
    gnt_mode = 0;
    do_reset();
    run_to_valid(vcyc);
    checks++; if (grant_addr.size() !== 4) begin errors++; $display("FAIL cold_ngrants got %0d exp 4", grant_addr.size()); end
    for (int i = 0; i < 4 && i < grant_addr.size(); i++) begin
      checks++; if (grant_addr[i] !== ADDR_W'(i)) begin errors++; $display("FAIL cold_addr%0d got %h exp %h", i, grant_addr[i], i); end
    end
    checks++; if (we_cnt !== 1) begin errors++; $display("FAIL cold_we_cnt got %0d exp 1", we_cnt); end
    checks++; if (we_addr !== 32'd0 || we_data !== 32'h00000013) begin errors++; $display("FAIL cold_write got %h/%h exp 0/00000013", we_addr, we_data); end
    // cycle 0 IDLE miss, 1-4 grants, 5 last byte, 6 WRITE, 7 hit, 8 visible
    checks++; if (we_cyc !== 6) begin errors++; $display("FAIL cold_we_cycle got %0d exp 6", we_cyc); end
    checks++; if (vcyc !== 8) begin errors++; $display("FAIL cold_valid_cycle got %0d exp 8", vcyc); end
    checks++; if (s_pc !== 32'd0 || s_inst !== 32'h00000013) begin errors++; $display("FAIL cold_deliver got %h/%h exp 0/00000013", s_pc, s_inst); end
  endtask

  task automatic test_warm_cache();
    logic [31:0] w [0:2];
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    do_reset();
    for (int i = 0; i < 3; i++) preload(32'(4 * i), w[i]);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i >= 1) begin
        checks++;
        if (s_valid !== 1'b1 || s_pc !== 32'(4 * (i - 1)) || s_inst !== w[i-1]) begin
          errors++; $display("FAIL warm_deliver%0d got %b/%h/%h exp 1/%h/%h", i - 1, s_valid, s_pc, s_inst, 4 * (i - 1), w[i-1]);
        end
      end
    end
    checks++; if (req_cnt !== 0) begin errors++; $display("FAIL warm_no_req got %0d exp 0", req_cnt); end
  endtask

  task automatic test_grant_gap();
    int vcyc;
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    gnt_mode = 1; gap_len = 3;
    do_reset();
    run_to_valid(vcyc);
    checks++; if (we_cyc !== 6 + 3) begin errors++; $display("FAIL gap_we_cycle got %0d exp 9", we_cyc); end
    checks++; if (we_data !== word(0)) begin errors++; $display("FAIL gap_write got %h exp %h", we_data, word(0)); end
    checks++; if (vcyc !== 8 + 3 || s_inst !== word(0)) begin errors++; $display("FAIL gap_deliver got %0d/%h exp 11/%h", vcyc, s_inst, word(0)); end
    gnt_mode = 0;
  endtask

  task automatic test_jump();
    int vcyc, g0;
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    for (int i = 256; i < 260; i++) mem[i] = 8'($urandom);
    gnt_mode = 0;
    do_reset();
    for (int i = 0; i < 4; i++) step();   // two bytes captured by now
    bus.jump_i = 1'b1; bus.jump_addr_i = 32'h100;
    step();
    bus.jump_i = 1'b0;
    g0 = grant_addr.size();
    checks++; if (bus.if_valid_o !== 1'b0 || bus.raddr_o !== 32'h100) begin errors++; $display("FAIL jump_redirect got %b/%h exp 0/00000100", bus.if_valid_o, bus.raddr_o); end
    run_to_valid(vcyc);
    checks++; if (grant_addr.size() <= g0 || grant_addr[g0] !== ADDR_W'(32'h100)) begin errors++; $display("FAIL jump_next_addr got size %0d exp addr 100", grant_addr.size()); end
    checks++; if (we_cnt !== 1 || we_addr !== 32'h100) begin errors++; $display("FAIL jump_writes got %0d/%h exp 1/00000100", we_cnt, we_addr); end
    checks++; if (vcyc < 0 || s_pc !== 32'h100 || s_inst !== word(32'h100)) begin errors++; $display("FAIL jump_deliver got %h/%h exp 00000100/%h", s_pc, s_inst, word(32'h100)); end
  endtask

  task automatic test_stall_rdy();
    int vcyc;
    logic [31:0] w4;
    bit ok;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    w4 = $urandom;
    gnt_mode = 0;
    do_reset();
    preload(32'd0, word(0));
    preload(32'd4, w4);
    step(); step();                      // pc 4 has just been latched
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'd4 || s_inst !== w4) begin
        errors++; $display("FAIL stall_hold%0d got %b/%h/%h exp 1/00000004/%h", i, s_valid, s_pc, s_inst, w4);
      end
    end
    bus.stall_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (s_valid && s_pc !== 32'd4) ok = 1'b1;
    end
    checks++; if (!ok || s_pc !== 32'd8 || s_inst !== word(8)) begin errors++; $display("FAIL stall_resume got %h/%h exp 00000008/%h", s_pc, s_inst, word(8)); end

    // Freeze mid-fill with rdy low, then resume.
    do_reset();
    for (int i = 0; i < 3; i++) step();
    bus.rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s_req !== 1'b0 || s_we !== 1'b0 || s_valid !== 1'b0 || s_raddr !== 32'd0) begin
        errors++; $display("FAIL rdy_freeze%0d got req %b we %b valid %b raddr %h exp 0 0 0 0", i, s_req, s_we, s_valid, s_raddr);
      end
    end
    bus.rdy = 1'b1;
    run_to_valid(vcyc);
    checks++; if (we_data !== word(0) || we_cyc !== 6 + 5) begin errors++; $display("FAIL rdy_write got %h@%0d exp %h@11", we_data, we_cyc, word(0)); end
    checks++; if (s_inst !== word(0) || s_pc !== 32'd0) begin errors++; $display("FAIL rdy_deliver got %h/%h exp 0/%h", s_pc, s_inst, word(0)); end
    checks++; if (grant_addr.size() !== 4 || grant_addr[3] !== ADDR_W'(3)) begin errors++; $display("FAIL rdy_grants got %0d exp 4", grant_addr.size()); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic        p_valid, p_hold;
    logic [31:0] p_pc, p_inst;
    int          delivered;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    gnt_mode = 2;
    do_reset();
    exp_pc = 32'd0; delivered = 0; p_valid = 1'b0; p_hold = 1'b0; p_pc = 32'd0; p_inst = 32'd0;
    for (int n = 0; n < 800; n++) begin
      bus.stall_i = ($urandom_range(0, 3) == 0);
      bus.rdy     = ($urandom_range(0, 9) != 0);
      step();
      if (s_we) begin
        checks++; if (s_winst !== word(s_waddr)) begin errors++; $display("FAIL rnd_write at %h got %h exp %h", s_waddr, s_winst, word(s_waddr)); end
      end
      if (p_valid && p_hold) begin
        checks++; if (s_valid !== 1'b1 || s_pc !== p_pc || s_inst !== p_inst) begin errors++; $display("FAIL rnd_hold got %b/%h/%h exp 1/%h/%h", s_valid, s_pc, s_inst, p_pc, p_inst); end
      end
      if (s_valid && !s_stall && s_rdy) begin
        checks++; if (s_pc !== exp_pc || s_inst !== word(exp_pc)) begin errors++; $display("FAIL rnd_deliver got %h/%h exp %h/%h", s_pc, s_inst, exp_pc, word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      p_valid = s_valid; p_hold = s_stall || !s_rdy; p_pc = s_pc; p_inst = s_inst;
    end
    checks++; if (delivered < 10) begin errors++; $display("FAIL rnd_progress got %0d exp >=10", delivered); end
    bus.stall_i = 1'b0; bus.rdy = 1'b1; gnt_mode = 0;
  endtask

  initial begin
    bus.rdy = 1'b1; bus.jump_i = 1'b0; bus.jump_addr_i = 32'd0; bus.stall_i = 1'b0;
    bus.mem_data_i = 8'd0; gnt_en = 1'b1; gnt_mode = 0; gap_len = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) begin c_valid[i] = 1'b0; c_tag[i] = 22'd0; c_data[i] = 32'd0; end
    test_reset();
    test_cold_miss();
    test_warm_cache();
    test_grant_gap();
    test_jump();
    test_stall_rdy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
